// File: rtl/ps2_host_rx_fifo_pkg.sv
// Shared types and constants for the PS/2 host receiver: FSM states,
// error-flag bit positions and the FIFO entry layout.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        PUSH   = 3'd4
    } ps2_state_e;

    localparam int PS2_FRAME_BITS = 11;

    localparam int ERR_START  = 0;
    localparam int ERR_PARITY = 1;
    localparam int ERR_STOP   = 2;

    typedef struct packed {
        logic [2:0] err;
        logic [7:0] data;
    } ps2_rx_entry_t;

    // Parity is checked over the eight data bits plus the received parity bit.
    function automatic logic parity_bad(input logic [7:0] d, input logic p, input logic odd);
        return (^{d, p}) != odd;
    endfunction

endpackage

// File: rtl/ps2_host_rx_fifo_if.sv
// Valid/ready stream carrying decoded PS/2 bytes and their error flags.
interface ps2_host_rx_fifo_if;
    import ps2_pkg::*;

    logic [7:0] m_data;
    logic [2:0] m_err;
    logic       m_valid;
    logic       m_ready;

    modport master (output m_data, output m_err, output m_valid, input m_ready);
    modport slave  (input m_data, input m_err, input m_valid, output m_ready);

endinterface

// File: rtl/ps2_host_rx_fifo_fifo.sv
// Generic synchronous FIFO with occupancy count; head entry is read
// combinationally from storage so a pop exposes the next entry at once.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int WIDTH = PS2_FRAME_BITS,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             full, do_push, do_pop;

    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop & (level != '0);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign valid = (level != '0);

endmodule

// File: rtl/ps2_host_rx_fifo.sv
// PS/2 host receiver: pin synchronise/deglitch, frame FSM with watchdog,
// decoded-byte FIFO and a clock-inhibit request toward the pad.
module ps2_host_rx_fifo
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int DEPTH          = 8,
    parameter int PARITY_ODD     = 1
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         rx_en,
    input  logic                         ps2_clk,
    input  logic                         ps2_data,
    ps2_host_rx_fifo_if.master           m,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         overflow,
    output logic                         timeout,
    input  logic                         clr_flags,
    output logic                         ps2_clk_inhibit
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Lane 0 is the PS/2 clock, lane 1 the PS/2 data; both idle high.
    logic [1:0] pin_raw, line_f;
    assign pin_raw = {ps2_data, ps2_clk};

    for (genvar i = 0; i < 2; i++) begin : g_line
        logic [SYNC_STAGES-1:0] sync_q;

        always_ff @(posedge sys_clk) begin
            if (sys_rst) sync_q <= '1;
            else         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_raw[i]};
        end

        if (FILTER_LEN == 0) begin : g_bypass
            assign line_f[i] = sync_q[SYNC_STAGES-1];
        end else begin : g_filt
            localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
            logic [CW-1:0] cnt;
            logic          filt;

            // The filtered line flips only after FILTER_LEN consecutive disagreeing samples.
            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    cnt  <= '0;
                    filt <= 1'b1;
                end else if (sync_q[SYNC_STAGES-1] == filt) begin
                    cnt <= '0;
                end else if (cnt == CW'(FILTER_LEN - 1)) begin
                    filt <= sync_q[SYNC_STAGES-1];
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
            assign line_f[i] = filt;
        end
    end

    logic clk_f_q, strobe, data_f;
    assign data_f = line_f[1];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) clk_f_q <= 1'b1;
        else         clk_f_q <= line_f[0];
    end

    assign strobe = rx_en & clk_f_q & ~line_f[0];

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          start_q, par_q, stop_q;
    logic [TW-1:0] wd_cnt;
    logic          push, wd_active, wd_expire;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (strobe) state_d = DATA;
            DATA:    if (strobe && bit_cnt == 3'd7) state_d = PARITY;
            PARITY:  if (strobe) state_d = STOP;
            STOP:    if (strobe) state_d = PUSH;
            PUSH:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (wd_expire || !rx_en) state_d = IDLE;
    end

    always_comb begin
        push      = 1'b0;
        wd_active = 1'b0;
        case (state_q)
            DATA, PARITY, STOP: wd_active = 1'b1;
            PUSH:               push      = 1'b1;
            default:            ;
        endcase
        wd_expire = wd_active && (wd_cnt == TW'(TIMEOUT_CYCLES));
    end

    // Every bit is captured regardless of framing errors; errors are only flagged.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bit_cnt <= '0;
            shift_q <= '0;
            start_q <= 1'b0;
            par_q   <= 1'b0;
            stop_q  <= 1'b1;
            wd_cnt  <= '0;
        end else begin
            if (!wd_active || strobe) wd_cnt <= '0;
            else                      wd_cnt <= wd_cnt + TW'(1);
            if (strobe) begin
                case (state_q)
                    IDLE: begin
                        start_q <= data_f;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        shift_q <= {data_f, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY:  par_q  <= data_f;
                    STOP:    stop_q <= data_f;
                    default: ;
                endcase
            end
        end
    end

    ps2_rx_entry_t wr_entry, head;
    logic          fifo_drop;

    always_comb begin
        wr_entry                  = '0;
        wr_entry.data             = shift_q;
        wr_entry.err[ERR_START]   = start_q;
        wr_entry.err[ERR_PARITY]  = parity_bad(shift_q, par_q, 1'(PARITY_ODD));
        wr_entry.err[ERR_STOP]    = ~stop_q;
    end

    ps2_rx_fifo #(
        .WIDTH ($bits(ps2_rx_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (push),
        .wdata (wr_entry),
        .pop   (m.m_ready),
        .rdata (head),
        .valid (m.m_valid),
        .level (fifo_level),
        .drop  (fifo_drop)
    );

    assign m.m_data = head.data;
    assign m.m_err  = head.err;

    // Set beats clear; inhibit only requested while no frame is in flight.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            overflow        <= 1'b0;
            timeout         <= 1'b0;
            ps2_clk_inhibit <= 1'b0;
        end else begin
            overflow        <= fifo_drop | (overflow & ~clr_flags);
            timeout         <= wd_expire | (timeout & ~clr_flags);
            ps2_clk_inhibit <= (fifo_level == LW'(DEPTH)) && (state_d == IDLE);
        end
    end

endmodule
